// File: rtl/maxpool2x2_bram_ctrl.sv
// 2x2 stride-2 max-pool controller: even rows park per-pair horizontal maxima in a
// half-row BRAM, odd rows read them back and emit the pooled maximum.
module maxpool2x2_bram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  bram_wr_en,
  output logic [ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [DATA_WIDTH-1:0] bram_rd_data
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] PAIR_LAST = ADDR_WIDTH'(IMG_WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVEN = 2'd1,
    S_ODD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [ADDR_WIDTH-1:0]   pair_q, pair_d;
  logic [DATA_WIDTH-1:0]   first_q, first_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic                    done_q, done_d;

  logic                    pipe_ok;
  logic                    accept;
  logic                    col_last;
  logic                    row_last;
  logic                    out_hs;
  logic [DATA_WIDTH-1:0]   hmax;
  logic [DATA_WIDTH-1:0]   pooled;

  assign pipe_ok  = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign out_hs   = out_valid_q && out_ready;
  assign hmax     = (in_data > first_q) ? in_data : first_q;
  assign pooled   = (hmax > bram_rd_data) ? hmax : bram_rd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = start ? S_EVEN : S_IDLE;
      S_EVEN: state_d = (accept && col_last) ? S_ODD : S_EVEN;
      S_ODD: begin
        if (accept && col_last) begin
          state_d = row_last ? S_DONE : S_EVEN;
        end else begin
          state_d = S_ODD;
        end
      end
      S_DONE:  state_d = (out_hs && out_last_q) ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write enable follows the accept combinationally so each pair lands in one cycle.
  always_comb begin
    busy       = 1'b0;
    in_ready   = 1'b0;
    bram_wr_en = 1'b0;
    case (state_q)
      S_EVEN: begin
        busy       = 1'b1;
        in_ready   = pipe_ok;
        bram_wr_en = in_valid && pipe_ok && col_q[0];
      end
      S_ODD: begin
        busy     = 1'b1;
        in_ready = pipe_ok;
      end
      default: begin
        busy       = 1'b0;
        in_ready   = 1'b0;
        bram_wr_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    pair_d      = pair_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = (state_q == S_DONE) && out_hs && out_last_q;
    if (out_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0]) begin
        first_d = in_data;
      end else begin
        // rd_addr only moves here, so the next pair's read has a full cycle to settle.
        pair_d = (pair_q == PAIR_LAST) ? '0 : pair_q + 1'b1;
        if (state_q == S_ODD) begin
          out_data_d  = pooled;
          out_valid_d = 1'b1;
          out_last_d  = row_last && col_last;
        end else begin
          out_data_d = out_data_q;
        end
      end
    end else begin
      col_d = col_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      first_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      pair_q      <= pair_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign done         = done_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign bram_wr_addr = pair_q;
  assign bram_wr_data = hmax;
  assign bram_rd_addr = pair_q;

endmodule

// File: tb/tb_maxpool2x2_bram_ctrl.sv
// Randomised bench for maxpool2x2_bram_ctrl: a 4x4 instance checked every cycle against a
// frame-level pooling model, plus a 2x2 instance for the minimum-width corner.
module tb_maxpool2x2_bram_ctrl;
  localparam int DW = 8, W = 4, H = 4, AW = 4, NPIX = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, in_valid, out_ready, busy, done, in_ready, out_valid, out_last, bram_wr_en;
  logic [DW-1:0] in_data, out_data, bram_wr_data, bram_rd_data;
  logic [AW-1:0] bram_wr_addr, bram_rd_addr;

  maxpool2x2_bram_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
    .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data));

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_data;
    bram_rd_data <= mem[bram_rd_addr];
  end

  // second instance: 2x2 frame
  logic start2, in_valid2, out_ready2, busy2, done2, in_ready2, out_valid2, out_last2, wr_en2;
  logic [DW-1:0] in_data2, out_data2, wr_data2, rd_data2;
  logic [1:0] wr_addr2, rd_addr2;

  maxpool2x2_bram_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(2), .IMG_HEIGHT(2), .ADDR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_last(out_last2),
    .bram_wr_en(wr_en2), .bram_wr_addr(wr_addr2), .bram_wr_data(wr_data2),
    .bram_rd_addr(rd_addr2), .bram_rd_data(rd_data2));

  logic [DW-1:0] mem2 [0:3];
  always @(posedge clk) begin
    if (wr_en2) mem2[wr_addr2] <= wr_data2;
    rd_data2 <= mem2[rd_addr2];
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int pix [NPIX];
  int exp_out[$], exp_wa[$], exp_wd[$];
  bit exp_last[$];
  bit model_busy = 1'b0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void build_model();
    exp_out.delete(); exp_last.delete(); exp_wa.delete(); exp_wd.delete();
    for (int r = 0; r < H; r += 2) begin
      for (int c = 0; c < W; c += 2) begin
        int top, bot;
        top = imax(pix[r*W+c], pix[r*W+c+1]);
        bot = imax(pix[(r+1)*W+c], pix[(r+1)*W+c+1]);
        exp_wa.push_back(c / 2);
        exp_wd.push_back(top);
        exp_out.push_back(imax(top, bot));
        exp_last.push_back((r == H - 2) && (c == W - 2));
      end
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  bit prev_hold = 1'b0, prev_fin = 1'b0, prev_last = 1'b0;
  int prev_data = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
      prev_fin  = 1'b0;
    end else begin
      chk("done_pulse", done, prev_fin);
      chk("busy", busy, model_busy);
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid && !out_ready) chk("in_ready_backpressure", in_ready, 0);
      if (!model_busy) chk("in_ready_not_busy", in_ready, 0);
      if (bram_wr_en) begin
        if (exp_wa.size() == 0) chk("wr_unexpected", bram_wr_en, 0);
        else begin
          chk("wr_addr", bram_wr_addr, exp_wa.pop_front());
          chk("wr_data", bram_wr_data, exp_wd.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) chk("out_unexpected", out_valid, 0);
        else begin
          chk("out_data", out_data, exp_out.pop_front());
          chk("out_last", out_last, exp_last.pop_front());
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      prev_fin  = out_valid && out_ready && out_last;
      if (done) done_cnt++;
    end
  end

  // 2x2 instance capture
  int out2[$], last2[$], wd2[$], wa2[$];
  int done2_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid2 && out_ready2) begin out2.push_back(out_data2); last2.push_back(out_last2); end
      if (wr_en2) begin wd2.push_back(wr_data2); wa2.push_back(wr_addr2); end
      if (done2) done2_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic ready_pat(input int mode, input int n);
    case (mode)
      0: return 1'b1;
      1: return (n % 3) == 0;
      default: return logic'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wr_en"}, bram_wr_en, 0);
    chk({tag, "_rd_addr"}, bram_rd_addr, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic run_frame(input int bp_mode, input bit rand_valid, input int stop_after,
                           output bit aborted);
    int idx = 0, cyc = 0, n = 0, d0;
    d0 = done_cnt;
    aborted = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; model_busy = 1'b1;
    while (idx < NPIX && cyc < 3000) begin
      if (stop_after > 0 && idx >= stop_after) begin
        aborted = 1'b1;
        return;
      end
      in_valid  = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data   = DW'(pix[idx]);
      out_ready = ready_pat(bp_mode, n);
      start     = (cyc == 2);
      n++;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0; start = 1'b0; model_busy = 1'b0;
    chk("pixels_accepted", idx, NPIX);
    while (done_cnt == d0 && cyc < 3000) begin
      out_ready = ready_pat(bp_mode, n); n++;
      @(negedge clk);
      @(posedge clk); #1; cyc++;
    end
    chk("done_once", done_cnt - d0, 1);
    chk("outs_left", exp_out.size(), 0);
    chk("writes_left", exp_wa.size(), 0);
    out_ready = 1'b1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < NPIX; i++) pix[i] = i;
    build_model();
  endtask

  bit ab;
  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    start2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1; in_data2 = '0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1; rst = 1'b1;

    // pixels in IDLE are ignored
    in_valid = 1'b1; in_data = 8'd77;
    repeat (5) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_wr_en", bram_wr_en, 0);
    end
    @(posedge clk); #1; in_valid = 1'b0;

    // pin the model against hand-computed values for the 0..15 ramp
    load_ramp();
    chk("model_o0", exp_out[0], 5);  chk("model_o1", exp_out[1], 7);
    chk("model_o2", exp_out[2], 13); chk("model_o3", exp_out[3], 15);
    chk("model_last", exp_last[3], 1);
    chk("model_w0", exp_wd[0], 1);   chk("model_w2", exp_wd[2], 9);
    chk("model_wa3", exp_wa[3], 1);
    run_frame(0, 1'b0, 0, ab);

    load_ramp();
    run_frame(1, 1'b0, 0, ab);

    // ties / extremes
    pix = '{255, 0, 7, 7, 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 8; i < NPIX; i++) pix[i] = $urandom_range(0, 255);
    build_model();
    chk("model_tie0", exp_out[0], 255);
    chk("model_tie1", exp_out[1], 7);
    run_frame(2, 1'b1, 0, ab);

    // reset in the middle of the first odd row
    load_ramp();
    run_frame(0, 1'b0, 6, ab);
    chk("aborted", ab, 1);
    in_valid = 1'b1;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_busy = 1'b0;
    exp_out.delete(); exp_last.delete(); exp_wa.delete(); exp_wd.delete();
    in_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    load_ramp();
    run_frame(0, 1'b0, 0, ab);

    // random frames
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NPIX; i++)
        pix[i] = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
      build_model();
      run_frame(f % 3, f[0], 0, ab);
    end

    // 2x2 frame, back-to-back pixels 3,9,4,1
    @(posedge clk); #1; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int v;
      case (i)
        0: v = 3;
        1: v = 9;
        2: v = 4;
        default: v = 1;
      endcase
      in_valid2 = 1'b1; in_data2 = DW'(v);
      @(negedge clk);
      chk("w2_in_ready", in_ready2, 1);
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("w2_out_count", out2.size(), 1);
    if (out2.size() == 1) begin
      chk("w2_out_data", out2[0], 9);
      chk("w2_out_last", last2[0], 1);
    end
    chk("w2_wr_count", wd2.size(), 1);
    if (wd2.size() == 1) begin
      chk("w2_wr_data", wd2[0], 9);
      chk("w2_wr_addr", wa2[0], 0);
    end
    chk("w2_done", done2_cnt, 1);
    chk("w2_busy_after", busy2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maxpool2x2_bram_ctrl.md
Name: maxpool2x2_bram_ctrl

Overview:
- Sequences a single dual-port BRAM (1 write port, 1 registered read port, 1-cycle read latency) as a half-row line buffer for 2x2, stride-2 max pooling of a raster-order pixel stream.
- Even rows: the horizontal max of each pixel pair is written to BRAM. Odd rows: the matching entry is read back and the pooled max is emitted.
- Sits between the pixel source and the downstream feature consumer. One frame per start pulse.

Parameters:
- DATA_WIDTH, 8, pixel width; unsigned compare.
- IMG_WIDTH, 8, pixels per row; even, >= 2.
- IMG_HEIGHT, 8, rows per frame; even, >= 2.
- ADDR_WIDTH, 4, BRAM address width; 2**ADDR_WIDTH >= IMG_WIDTH/2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle frame start; honoured only in IDLE.
- busy  out  1  high in EVEN/ODD states.
- done  out  1  one-cycle pulse after the last pooled output handshakes.
- in_valid  in  1  pixel valid.
- in_ready  out  1  pixel accept.
- in_data  in  DATA_WIDTH  pixel.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  pooled max.
- out_last  out  1  qualifies the final pooled result of the frame.
- bram_wr_en  out  1  BRAM write enable.
- bram_wr_addr  out  ADDR_WIDTH  BRAM write address.
- bram_wr_data  out  DATA_WIDTH  BRAM write data.
- bram_rd_addr  out  ADDR_WIDTH  BRAM read address.
- bram_rd_data  in  DATA_WIDTH  BRAM registered read data.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; col, row, pair_idx = 0; first-pixel register = 0.
  - Outputs: out_valid=0, out_data=0, out_last=0, done=0, busy=0, bram_wr_en=0, bram_rd_addr=0, in_ready=0.
  - Reset mid-frame abandons the frame. BRAM contents need no clearing; the next even row overwrites them.
- FSM:
  - IDLE -> EVEN on start. start while busy is ignored.
  - EVEN -> ODD after the last pixel of the row is accepted.
  - ODD -> EVEN after the last pixel of the row is accepted, unless it is the last row.
  - ODD (last row) -> DONE after the last pixel of the frame is accepted.
  - DONE -> IDLE once the out_last beat handshakes; done pulses in the cycle after that handshake.
- Input handshake:
  - in_ready = (state is EVEN or ODD) and (!out_valid or out_ready).
  - A pixel is accepted when in_valid and in_ready are both high.
  - col increments per accepted pixel and wraps at IMG_WIDTH-1. row increments on wrap.
- Pairing:
  - Even col: pixel is latched in the first-pixel register.
  - Odd col: hmax = max(first, in_data). pair_idx increments after the pair and wraps to 0 at row end.
- EVEN row: on each odd-col accept, bram_wr_en=1 for that cycle only (combinational from the accept), bram_wr_addr=pair_idx, bram_wr_data=hmax.
- ODD row:
  - bram_rd_addr = pair_idx at all times; it changes only on pair completion.
  - By the second pixel's accept, rd_addr has been stable >= 1 cycle, so bram_rd_data is valid with no stall. This holds for back-to-back pixels, including across row wrap and IMG_WIDTH=2.
  - On each odd-col accept, register out_data = max(hmax, bram_rd_data) and set out_valid=1. out_last=1 if this is the final pair of the frame.
- Output:
  - out_valid is held with stable out_data/out_last until out_ready.
  - A same-cycle new result and downstream accept overwrites the register; no bubble.
  - Ties: equal values yield that value.
- Latency: pooled result is valid the cycle after the 2nd pixel of the odd-row pair is accepted. Throughput is 1 pixel/cycle without backpressure.
- No writes in ODD rows and no reads matter in EVEN rows, so there is no read/write address collision.

Test Plan:
- 4x4 frame (IMG_WIDTH=IMG_HEIGHT=4), pixels 0..15 raster, out_ready=1, in_valid=1 continuous -> outputs 5,7,13,15; out_last only with 15; done pulses once; BRAM writes addr0=1, addr1=3, then addr0=9, addr1=11.
- Same frame with out_ready toggled 1,0,0,1... -> in_ready low whenever out_valid && !out_ready; out_data held stable; outputs unchanged (5,7,13,15); no pixel dropped or duplicated.
- Ties/extremes (DATA_WIDTH=8): row0 = 255,0,7,7; row1 = 0,0,7,7 -> outputs 255,7.
- IMG_WIDTH=2, IMG_HEIGHT=2: pixels 3,9,4,1 back-to-back -> single output 9 with out_last; rd_data sampled correctly despite adjacent write/read of addr0.
- rst pulsed low mid-odd-row of frame 1, then start with pixels 0..15 -> all outputs/state cleared immediately; second frame yields 5,7,13,15.
- start asserted during busy, and in_valid asserted in IDLE -> both ignored; in_ready=0 in IDLE/DONE; no BRAM writes.
